// File: rtl/key_strobe.sv
// Push-button conditioner: synchronizes and debounces a raw key level and
// emits single-cycle strobes on press, with optional auto-repeat while held.
module key_strobe #(
  parameter int debounce_cycles = 50000,
  parameter int repeat_delay    = 25000000,
  parameter int repeat_period   = 5000000,
  parameter bit active_low      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic repeat_en,
  output logic strobe,
  output logic pressed
);

  localparam int CNT_W  = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
  localparam int T_MAX  = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles - 1);
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(repeat_delay - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(repeat_period - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             REL_LVL  = active_low;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;
  logic             r_strobe;
  logic [TMR_W-1:0] r_timer;
  state_t           r_state;

  logic             w_level;
  logic             w_differs;
  logic             w_toggle;
  logic             w_rise;
  logic             w_fall;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_strobe_nxt;

  // Stage 0: two-flop synchronizer; reset parks it at the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level   = r_sync2 ^ REL_LVL;
  assign w_differs = (w_level != r_pressed);
  assign w_toggle  = w_differs && (r_cnt == CNT_LAST);
  assign w_rise    = w_toggle && !r_pressed;
  assign w_fall    = w_toggle &&  r_pressed;

  // Stage 1: debounce counter and accepted key state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      if (!w_differs || w_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_toggle) begin
        r_pressed <= ~r_pressed;
      end
    end
  end

  // Release overrides everything, including a repeat compare in the same cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_strobe_nxt = 1'b0;
    if (w_fall) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_strobe_nxt = 1'b1;
            w_timer_nxt  = '0;
            w_state_nxt  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!repeat_en) begin
            w_timer_nxt = '0;
          end else if (r_timer == DLY_LAST) begin
            w_strobe_nxt = 1'b1;
            w_timer_nxt  = '0;
            w_state_nxt  = S_REPEAT;
          end else begin
            w_timer_nxt = r_timer + TMR_ONE;
          end
        end
        S_REPEAT: begin
          if (!repeat_en) begin
            w_timer_nxt = '0;
            w_state_nxt = S_HOLD;
          end else if (r_timer == PER_LAST) begin
            w_strobe_nxt = 1'b1;
            w_timer_nxt  = '0;
          end else begin
            w_timer_nxt = r_timer + TMR_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // Stage 2: FSM state, repeat timer and registered strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign strobe  = r_strobe;
  assign pressed = r_pressed;

endmodule

// File: tb/tb_key_strobe.sv
// Directed bench for key_strobe: one active-high and one active-low instance
// (debounce 4, repeat delay 10, repeat period 3) driven from a linear script.
module tb_key_strobe;

  logic clk = 1'b0;
  logic rst;
  logic key0, key1, ren0, ren1;
  logic strobe0, pressed0, strobe1, pressed1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nstr0   = 0;
  int   nstr1   = 0;

  always #5 clk = ~clk;

  key_strobe #(
    .debounce_cycles(4), .repeat_delay(10), .repeat_period(3), .active_low(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .key_raw(key0), .repeat_en(ren0),
    .strobe(strobe0), .pressed(pressed0)
  );

  key_strobe #(
    .debounce_cycles(4), .repeat_delay(10), .repeat_period(3), .active_low(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .key_raw(key1), .repeat_en(ren1),
    .strobe(strobe1), .pressed(pressed1)
  );

  // Advance n rising edges, sampling 1 time unit after each; tallies strobes.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (strobe0 === 1'b1) nstr0++;
      if (strobe1 === 1'b1) nstr1++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    key0 = 1'b0;
    key1 = 1'b1;
    ren0 = 1'b0;
    ren1 = 1'b0;
    tick(3);
    chk("rst_strobe0", 32'(strobe0), 0);
    chk("rst_pressed0", 32'(pressed0), 0);
    chk("rst_strobe1", 32'(strobe1), 0);
    chk("rst_pressed1", 32'(pressed1), 0);
    rst = 1'b0;
    tick(2);
    chk("idle_pressed0", 32'(pressed0), 0);

    // 1: clean press, repeat disabled
    nstr0 = 0;
    key0  = 1'b1;
    tick(5);
    chk("t1_pressed_e5", 32'(pressed0), 0);
    chk("t1_strobe_e5", 32'(strobe0), 0);
    tick(1);
    chk("t1_pressed_e6", 32'(pressed0), 1);
    chk("t1_strobe_e6", 32'(strobe0), 1);
    tick(1);
    chk("t1_strobe_e7", 32'(strobe0), 0);
    tick(13);
    chk("t1_nstrobe_held", 32'(nstr0), 1);
    key0 = 1'b0;
    tick(5);
    chk("t1_rel_pressed_e5", 32'(pressed0), 1);
    tick(1);
    chk("t1_rel_pressed_e6", 32'(pressed0), 0);
    chk("t1_rel_strobe_e6", 32'(strobe0), 0);
    tick(4);
    chk("t1_nstrobe_total", 32'(nstr0), 1);

    // 2: bounce 1,0,1,1,0,1 then held
    nstr0 = 0;
    key0 = 1'b1; tick(1);
    key0 = 1'b0; tick(1);
    key0 = 1'b1; tick(2);
    key0 = 1'b0; tick(1);
    key0 = 1'b1;
    tick(5);
    chk("t2_pressed_e5", 32'(pressed0), 0);
    chk("t2_nstrobe_bounce", 32'(nstr0), 0);
    tick(1);
    chk("t2_pressed_e6", 32'(pressed0), 1);
    chk("t2_strobe_e6", 32'(strobe0), 1);
    tick(10);
    chk("t2_nstrobe", 32'(nstr0), 1);
    key0 = 1'b0;
    tick(6);
    chk("t2_released", 32'(pressed0), 0);
    tick(2);

    // 3: auto-repeat, then release landing on a repeat compare
    ren0  = 1'b1;
    nstr0 = 0;
    key0  = 1'b1;
    tick(6);
    chk("t3_strobe_T", 32'(strobe0), 1);
    tick(9);
    chk("t3_nstrobe_T9", 32'(nstr0), 1);
    tick(1);
    chk("t3_strobe_T10", 32'(strobe0), 1);
    tick(2);
    chk("t3_strobe_T12", 32'(strobe0), 0);
    tick(1);
    chk("t3_strobe_T13", 32'(strobe0), 1);
    tick(3);
    chk("t3_strobe_T16", 32'(strobe0), 1);
    tick(3);
    chk("t3_strobe_T19", 32'(strobe0), 1);
    chk("t3_nstrobe_T19", 32'(nstr0), 5);
    key0 = 1'b0;
    tick(3);
    chk("t3_strobe_T22", 32'(strobe0), 1);
    tick(3);
    chk("t4b_strobe_T25", 32'(strobe0), 0);
    chk("t4b_pressed_T25", 32'(pressed0), 0);
    tick(12);
    chk("t4b_nstrobe", 32'(nstr0), 6);

    // 4: release while in HOLD, pressed falls at T+5
    nstr0 = 0;
    key0  = 1'b1;
    tick(5);
    key0 = 1'b0;
    tick(1);
    chk("t4_strobe_T", 32'(strobe0), 1);
    chk("t4_pressed_T", 32'(pressed0), 1);
    tick(4);
    chk("t4_pressed_T4", 32'(pressed0), 1);
    tick(1);
    chk("t4_pressed_T5", 32'(pressed0), 0);
    chk("t4_strobe_T5", 32'(strobe0), 0);
    tick(10);
    chk("t4_nstrobe", 32'(nstr0), 1);

    // 5: reset mid-REPEAT with key held
    key0 = 1'b1;
    tick(6);
    chk("t5_strobe_T", 32'(strobe0), 1);
    tick(12);
    chk("t5_pressed_T12", 32'(pressed0), 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t5_rst_strobe", 32'(strobe0), 0);
      chk("t5_rst_pressed", 32'(pressed0), 0);
    end
    rst   = 1'b0;
    nstr0 = 0;
    tick(5);
    chk("t5_pressed_e5", 32'(pressed0), 0);
    chk("t5_nstrobe_e5", 32'(nstr0), 0);
    tick(1);
    chk("t5_strobe_e6", 32'(strobe0), 1);
    chk("t5_pressed_e6", 32'(pressed0), 1);
    key0 = 1'b0;
    ren0 = 1'b0;
    tick(8);
    chk("t5_released", 32'(pressed0), 0);

    // 6: active-low instance
    chk("t6_idle_nstrobe", 32'(nstr1), 0);
    chk("t6_idle_pressed", 32'(pressed1), 0);
    key1 = 1'b0;
    tick(5);
    chk("t6_pressed_e5", 32'(pressed1), 0);
    tick(1);
    chk("t6_pressed_e6", 32'(pressed1), 1);
    chk("t6_strobe_e6", 32'(strobe1), 1);
    key1 = 1'b1;
    tick(6);
    chk("t6_released", 32'(pressed1), 0);
    chk("t6_nstrobe", 32'(nstr1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
